// File: rtl/display_sched_pkg.sv
// ---------------------------------------------------------------------------
// disp_sched_pkg
//
// Shared definitions for the two-page display scheduler (display_sched) and
// its dwell/gap counter (dwell_timer).
//
//   DATA_W  : width of a word accepted from the producer (64)
//   DISP_W  : width of one displayed page, i.e. half a word (32)
//   CNT_W   : width of the dwell/gap counter (32)
//   state_e : scheduler states; GAP_HI / GAP_LO exist only when the
//             optional blank-gap feature is built (macro DISP_SCHED_GAP_EN)
//
// Helper functions upper_half / lower_half split a word into its two pages.
// ---------------------------------------------------------------------------
package disp_sched_pkg;

    localparam int DATA_W = 64;
    localparam int DISP_W = 32;
    localparam int CNT_W  = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SHOW_HI = 3'd1,
        ST_SHOW_LO = 3'd2
`ifdef DISP_SCHED_GAP_EN
        ,
        ST_GAP_HI  = 3'd3,
        ST_GAP_LO  = 3'd4
`endif
    } state_e;

    function automatic logic [DISP_W-1:0] upper_half(input logic [DATA_W-1:0] w);
        return w[DATA_W-1:DISP_W];
    endfunction

    function automatic logic [DISP_W-1:0] lower_half(input logic [DATA_W-1:0] w);
        return w[DISP_W-1:0];
    endfunction

endpackage

// File: rtl/display_sched_dwell_timer.sv
// ---------------------------------------------------------------------------
// dwell_timer
//
// Free-running page counter for display_sched. Counts 0 .. limit-1 while
// enabled and wraps to 0 on the terminal count; a load forces it back to 0
// and has priority over counting.
//
// Ports
//   clk      in   clock
//   rstn     in   asynchronous active-low reset (counter -> 0)
//   load     in   synchronous restart at 0 (priority over enable)
//   enable   in   advance the count this cycle; low freezes the count
//   limit    in   CNT_W  number of cycles in the current period (>= 1)
//   terminal out  count currently equals limit-1
// ---------------------------------------------------------------------------
module dwell_timer
    import disp_sched_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic             terminal
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // terminal is a pure function of the count so the owner can decide,
    // together with its own freeze condition, whether to act on it.
    assign terminal = (cnt_q == (limit - CNT_W'(1)));

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = terminal ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/display_sched.sv
// ---------------------------------------------------------------------------
// display_sched
//
// Shows 64-bit words on a 32-bit (8-digit) display as two pages: the upper
// half for DWELL_CYCLES cycles, then the lower half for DWELL_CYCLES cycles,
// alternating forever. A one-entry pending buffer lets the producer queue
// the next word; it replaces the current word at the end of the lower page.
//
// Optional feature (macro DISP_SCHED_GAP_EN): after each page the display
// is blanked (disp_en = 0) for GAP_CYCLES cycles before the next page.
//
// Parameters
//   CLK_FREQUENCY  clock rate in Hz
//   DWELL_CYCLES   cycles each page is shown (2 .. 2^32-1)
//   GAP_CYCLES     blank cycles between pages (1 .. 2^32-1, gap build only)
//
// Ports
//   clk        in   clock
//   rstn       in   asynchronous active-low reset
//   in_valid   in   producer offers in_data
//   in_ready   out  a word can be accepted this cycle
//   in_data    in   64  word to display
//   hold       in   freeze counter and state (transfers still allowed)
//   clear      in   synchronous abort to IDLE, drops the pending word
//   disp_data  out  32  page driven to the display
//   disp_en    out  display enable
//   page       out  0 = upper half shown, 1 = lower half shown
//   busy       out  scheduler is not IDLE
// ---------------------------------------------------------------------------
module display_sched
    import disp_sched_pkg::*;
#(
    parameter int unsigned CLK_FREQUENCY = 100_000_000,
    parameter int unsigned DWELL_CYCLES  = CLK_FREQUENCY,
    parameter int unsigned GAP_CYCLES    = CLK_FREQUENCY / 10
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              hold,
    input  logic              clear,
    output logic [DISP_W-1:0] disp_data,
    output logic              disp_en,
    output logic              page,
    output logic              busy
);

    // Reject illegal parameterisations at elaboration time.
    if (CLK_FREQUENCY == 0) begin : g_bad_clk
        $error("display_sched: CLK_FREQUENCY must be non-zero");
    end
    if (DWELL_CYCLES < 2) begin : g_bad_dwell
        $error("display_sched: DWELL_CYCLES must be at least 2");
    end
    if (GAP_CYCLES < 1) begin : g_bad_gap
        $error("display_sched: GAP_CYCLES must be at least 1");
    end

    // The word swap (pending -> current, or bypass of a fresh word) happens
    // at the end of the last state of a full HI/LO round.
`ifdef DISP_SCHED_GAP_EN
    localparam state_e RELOAD_ST = ST_GAP_LO;
`else
    localparam state_e RELOAD_ST = ST_SHOW_LO;
`endif

    state_e            state_q;
    state_e            state_d;
    logic [DATA_W-1:0] current_q;
    logic [DATA_W-1:0] current_d;
    logic [DATA_W-1:0] pend_q;
    logic [DATA_W-1:0] pend_d;
    logic              pend_full_q;
    logic              pend_full_d;
    logic              ready_q;

    logic              xfer;
    logic              timer_load;
    logic              terminal;
    logic              adv;
    logic              reload;
    logic [CNT_W-1:0]  limit;

    // ready_q keeps in_ready low during reset and for the first edge after
    // release, so the producer never sees a ready before the block runs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    assign in_ready = ready_q && !pend_full_q && !clear;
    assign xfer     = in_valid && in_ready;

    // -----------------------------------------------------------------------
    // Page counter
    // -----------------------------------------------------------------------
`ifdef DISP_SCHED_GAP_EN
    assign limit = ((state_q == ST_GAP_HI) || (state_q == ST_GAP_LO))
                 ? CNT_W'(GAP_CYCLES) : CNT_W'(DWELL_CYCLES);
`else
    assign limit = CNT_W'(DWELL_CYCLES);
`endif

    // Holding the counter at 0 in IDLE means every page starts at count 0.
    assign timer_load = clear || (state_q == ST_IDLE);

    dwell_timer u_timer (
        .clk      (clk),
        .rstn     (rstn),
        .load     (timer_load),
        .enable   (!hold),
        .limit    (limit),
        .terminal (terminal)
    );

    // adv marks the single cycle in which a page (or gap) ends; it is the
    // only event that moves the FSM out of a display state.
    assign adv    = terminal && !hold && (state_q != ST_IDLE);
    assign reload = adv && (state_q == RELOAD_ST);

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (xfer) begin
                        state_d = ST_SHOW_HI;
                    end
                end
`ifdef DISP_SCHED_GAP_EN
                ST_SHOW_HI: if (adv) state_d = ST_GAP_HI;
                ST_GAP_HI:  if (adv) state_d = ST_SHOW_LO;
                ST_SHOW_LO: if (adv) state_d = ST_GAP_LO;
                ST_GAP_LO:  if (adv) state_d = ST_SHOW_HI;
`else
                ST_SHOW_HI: if (adv) state_d = ST_SHOW_LO;
                ST_SHOW_LO: if (adv) state_d = ST_SHOW_HI;
`endif
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // FSM: outputs
    // -----------------------------------------------------------------------
    // Gap states keep the page data and page flag of the page just shown and
    // only drop the enable, so the display blanks without the data flickering.
    always_comb begin
        disp_data = '0;
        disp_en   = 1'b0;
        page      = 1'b0;
        case (state_q)
            ST_SHOW_HI: begin
                disp_data = upper_half(current_q);
                disp_en   = 1'b1;
            end
            ST_SHOW_LO: begin
                disp_data = lower_half(current_q);
                disp_en   = 1'b1;
                page      = 1'b1;
            end
`ifdef DISP_SCHED_GAP_EN
            ST_GAP_HI: begin
                disp_data = upper_half(current_q);
            end
            ST_GAP_LO: begin
                disp_data = lower_half(current_q);
                page      = 1'b1;
            end
`endif
            default: begin
                disp_data = '0;
            end
        endcase
    end

    assign busy = (state_q != ST_IDLE);

    // -----------------------------------------------------------------------
    // Word storage: current word plus one-entry pending buffer
    // -----------------------------------------------------------------------
    always_comb begin
        current_d   = current_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        if (clear) begin
            pend_full_d = 1'b0;
        end else if (state_q == ST_IDLE) begin
            // Nothing is on display, so a new word goes straight to current.
            if (xfer) begin
                current_d = in_data;
            end
        end else if (reload) begin
            // A transfer cannot coincide with a full buffer (in_ready is low),
            // so the bypass branch only ever sees an empty buffer.
            if (pend_full_q) begin
                current_d   = pend_q;
                pend_full_d = 1'b0;
            end else if (xfer) begin
                current_d = in_data;
            end
        end else if (xfer) begin
            pend_d      = in_data;
            pend_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            current_q   <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
        end else begin
            current_q   <= current_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
        end
    end

endmodule

// File: tb/tb_display_sched.sv
module tb_display_sched;

    localparam int unsigned DW = 4;
    localparam int unsigned GW = 2;

    localparam logic [63:0] WA = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] WB = 64'hB0B1_B2B3_B4B5_B6B7;
    localparam logic [63:0] WC = 64'hC0C1_C2C3_C4C5_C6C7;
    localparam logic [63:0] WD = 64'hD0D1_D2D3_D4D5_D6D7;
    localparam logic [63:0] WE = 64'hE0E1_E2E3_E4E5_E6E7;
    localparam logic [63:0] WF = 64'hF0F1_F2F3_F4F5_F6F7;
    localparam logic [63:0] WG = 64'h1111_2222_3333_4444;
    localparam logic [63:0] WH = 64'h5555_6666_7777_8888;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        hold;
    logic        clear;
    logic [31:0] disp_data;
    logic        disp_en;
    logic        page;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic [31:0] ed;
    logic        epg;
    logic        eact;
    logic        erdy;

    display_sched #(
        .CLK_FREQUENCY (100),
        .DWELL_CYCLES  (DW),
        .GAP_CYCLES    (GW)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .hold      (hold),
        .clear     (clear),
        .disp_data (disp_data),
        .disp_en   (disp_en),
        .page      (page),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] hi(input logic [63:0] w);
        return w[63:32];
    endfunction

    function automatic logic [31:0] lo(input logic [63:0] w);
        return w[31:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] d, input logic en,
                           input logic pg, input logic bsy, input logic rdy);
        chk({tag, ".data"},  64'(disp_data), 64'(d));
        chk({tag, ".en"},    64'(disp_en),   64'(en));
        chk({tag, ".page"},  64'(page),      64'(pg));
        chk({tag, ".busy"},  64'(busy),      64'(bsy));
        chk({tag, ".ready"}, 64'(in_ready),  64'(rdy));
    endtask

    initial begin
        rstn     = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        hold     = 1'b0;
        clear    = 1'b0;

        // Reset state (posedge at 5 occurs with reset asserted)
        #12;
        chk_out("reset", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("rel_ready_pre", 64'(in_ready), 64'd0);
        @(negedge clk);
        chk_out("rel", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);

`ifdef DISP_SCHED_GAP_EN
        // 4 shown + 2 blank per page; word B offered at the GAP_LO terminal
        in_valid = 1'b1;
        in_data  = WA;
        for (int g = 0; g < 14; g++) begin
            @(negedge clk);
            if (g < 4)       begin ed = hi(WA); eact = 1'b1; epg = 1'b0; end
            else if (g < 6)  begin ed = hi(WA); eact = 1'b0; epg = 1'b0; end
            else if (g < 10) begin ed = lo(WA); eact = 1'b1; epg = 1'b1; end
            else if (g < 12) begin ed = lo(WA); eact = 1'b0; epg = 1'b1; end
            else             begin ed = hi(WB); eact = 1'b1; epg = 1'b0; end
            chk_out($sformatf("gap%0d", g), ed, eact, epg, 1'b1, 1'b1);
            if (g == 0)  in_valid = 1'b0;
            if (g == 11) begin in_valid = 1'b1; in_data = WB; end
            if (g == 12) in_valid = 1'b0;
        end
`else
        // Single word A: 4 cycles upper, 4 lower, repeating
        in_valid = 1'b1;
        in_data  = WA;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 0) in_valid = 1'b0;
            if (((i / 4) % 2) == 0) begin ed = hi(WA); epg = 1'b0; end
            else                    begin ed = lo(WA); epg = 1'b1; end
            chk_out($sformatf("single%0d", i), ed, 1'b1, epg, 1'b1, 1'b1);
        end

        // Return to IDLE via clear
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        chk_out("clr_idle", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        clear = 1'b0;
        #1;
        chk("clr_ready", 64'(in_ready), 64'd1);

        // Queue B and C behind A; hold; clear with pending full; reset mid-page
        in_valid = 1'b1;
        in_data  = WA;
        for (int k = 0; k < 54; k++) begin
            @(negedge clk);
            eact = 1'b1;
            if (k < 4)       begin ed = hi(WA); epg = 1'b0; end
            else if (k < 8)  begin ed = lo(WA); epg = 1'b1; end
            else if (k < 12) begin ed = hi(WB); epg = 1'b0; end
            else if (k < 16) begin ed = lo(WB); epg = 1'b1; end
            else if (k < 30) begin ed = hi(WC); epg = 1'b0; end
            else if (k < 34) begin ed = lo(WC); epg = 1'b1; end
            else if (k < 38) begin ed = hi(WD); epg = 1'b0; end
            else if (k < 40) begin ed = lo(WD); epg = 1'b1; end
            else if (k < 42) begin ed = 32'h0;  epg = 1'b0; eact = 1'b0; end
            else if (k < 46) begin ed = hi(WF); epg = 1'b0; end
            else if (k < 50) begin ed = lo(WF); epg = 1'b1; end
            else             begin ed = hi(WF); epg = 1'b0; end

            if (k == 0 || k == 8 || k == 16 || k == 17 || k == 34 ||
                (k >= 41 && k <= 51))
                erdy = 1'b1;
            else
                erdy = 1'b0;

            chk_out($sformatf("seq%0d", k), ed, eact, epg, eact, erdy);

            case (k)
                0:  in_data = WB;
                1:  in_data = WC;
                9:  in_valid = 1'b0;
                17: begin hold = 1'b1; in_valid = 1'b1; in_data = WD; end
                18: in_valid = 1'b0;
                27: hold = 1'b0;
                34: begin in_valid = 1'b1; in_data = WE; end
                35: in_valid = 1'b0;
                39: clear = 1'b1;
                40: clear = 1'b0;
                41: begin in_valid = 1'b1; in_data = WF; end
                42: in_valid = 1'b0;
                51: begin in_valid = 1'b1; in_data = WG; end
                52: in_valid = 1'b0;
                default: ;
            endcase
        end

        // Asynchronous reset in the middle of a page with G pending
        #2;
        rstn = 1'b0;
        #1;
        chk_out("async_rst", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("rst_rel_ready_pre", 64'(in_ready), 64'd0);
        @(negedge clk);
        chk_out("rst_rel", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        in_valid = 1'b1;
        in_data  = WH;
        for (int m = 0; m < 9; m++) begin
            @(negedge clk);
            if (m == 0) in_valid = 1'b0;
            if (m < 4)      begin ed = hi(WH); epg = 1'b0; end
            else if (m < 8) begin ed = lo(WH); epg = 1'b1; end
            else            begin ed = hi(WH); epg = 1'b0; end
            chk_out($sformatf("after_rst%0d", m), ed, 1'b1, epg, 1'b1, 1'b1);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/display_sched.md
DISPLAY_SCHED -- requirements
Module: display_sched

Interface
REQ-001 The block SHALL have parameter CLK_FREQUENCY, default 100_000_000, giving the clock rate in Hz.
REQ-002 The block SHALL have parameter DWELL_CYCLES, default CLK_FREQUENCY, giving the cycles each page is shown (legal range 2..2^32-1).
REQ-003 The block SHALL have parameter GAP_CYCLES, default CLK_FREQUENCY/10, giving blank cycles between pages (legal range 1..2^32-1; used only with DISP_SCHED_GAP_EN).
REQ-004 clk  in  1  the single clock for all sequential logic.
REQ-005 rstn  in  1  reset; asynchronous assertion, active-low.
REQ-006 in_valid  in  1  word offered.
REQ-007 in_ready  out  1  block can accept a word.
REQ-008 in_data  in  64  word to display (e.g. a cipher block).
REQ-009 hold  in  1  while high, the dwell/gap counter is frozen.
REQ-010 clear  in  1  synchronous abort back to IDLE.
REQ-011 disp_data  out  32  word driven to the 8-digit display datapath.
REQ-012 disp_en  out  1  display enable.
REQ-013 page  out  1  0 = upper half shown, 1 = lower half shown.
REQ-014 busy  out  1  high in every state other than IDLE.

Function
REQ-015 Storage SHALL be a current-word register plus a one-entry pending buffer; in_ready SHALL equal !pending_full && !clear.
REQ-016 A transfer SHALL occur on a clock edge where in_valid && in_ready.
REQ-017 The states SHALL be IDLE, SHOW_HI and SHOW_LO, plus GAP_HI and GAP_LO when DISP_SCHED_GAP_EN is defined.
REQ-018 In IDLE, disp_en SHALL be 0 and disp_data SHALL be 0.
REQ-019 In IDLE, a transfer SHALL load current directly (pending stays empty) and enter SHOW_HI with counter 0.
REQ-020 In the cycle after the IDLE transfer, disp_data SHALL equal in_data[63:32], disp_en SHALL be 1 and page SHALL be 0.
REQ-021 In SHOW_HI, disp_data SHALL be current[63:32]; in SHOW_LO, disp_data SHALL be current[31:0]; disp_en SHALL be 1 in both.
REQ-022 The counter SHALL count 0..DWELL_CYCLES-1 per page; reaching the terminal count SHALL advance the state and reset the counter to 0.
REQ-023 SHOW_HI SHALL advance to SHOW_LO.
REQ-024 When SHOW_LO advances, current SHALL be reloaded from pending if pending is full (clearing pending); otherwise current SHALL be retained, and the state SHALL return to SHOW_HI (endless alternation).
REQ-025 If pending is empty and a transfer coincides with the SHOW_LO terminal count, the new word SHALL bypass into current directly.
REQ-026 A transfer while pending is full is impossible (in_ready = 0); the producer SHALL stall.
REQ-027 While hold = 1, the counter and state SHALL not change, transfers into pending SHALL still be permitted, and outputs SHALL be stable.
REQ-028 clear = 1 SHALL take priority over all other events: next state IDLE, pending emptied, counter 0, no transfer accepted that cycle.
REQ-029 The counter SHALL be 32 bits wide, and its terminal compare SHALL be against the parameter minus 1.

Reset
REQ-030 rstn low SHALL asynchronously force: state IDLE, counter 0, pending empty, current 0, disp_data 0, disp_en 0, page 0, busy 0, in_ready 0.
REQ-031 After rstn deasserts, in_ready SHALL go to 1 on the first clk edge.
REQ-032 Reset asserted mid-page SHALL discard both the current and the pending word.

Configuration
REQ-033 With macro DISP_SCHED_GAP_EN defined, each SHOW_x terminal count SHALL enter GAP_x for GAP_CYCLES cycles, then take the transition REQ-023/024 would have taken; hold SHALL also freeze the gap counter.
REQ-034 In GAP_x, disp_en SHALL be 0 while disp_data and page keep their previous values.
REQ-035 With DISP_SCHED_GAP_EN defined, the bypass of REQ-025 SHALL apply at the GAP_LO terminal count instead of the SHOW_LO terminal count.
REQ-036 Without DISP_SCHED_GAP_EN, the GAP states and GAP_CYCLES logic SHALL be absent, and pages SHALL switch back-to-back.

Structure
REQ-037 Package disp_sched_pkg SHALL hold the state enum, DATA_W = 64, DISP_W = 32 and CNT_W = 32.
REQ-038 A sub-module dwell_timer SHALL provide the counter: inputs load, enable and limit; output terminal.

Verification (DWELL_CYCLES = 4, GAP_CYCLES = 2)
REQ-039 Reset, then send one word 0x0123456789ABCDEF -> disp_data = 0x01234567 for 4 cycles, then 0x89ABCDEF for 4 cycles, then repeating; page toggles.
REQ-040 While A is showing, send B then C -> B accepted and in_ready drops; C stalls until B moves to current at the end of A's SHOW_LO; B's upper half appears the next cycle.
REQ-041 Assert hold for 10 cycles in the middle of SHOW_HI -> the display stays on the upper half for 4 + 10 cycles total, and a word offered during hold is accepted into pending.
REQ-042 Assert clear during SHOW_LO with pending full -> the next cycle shows IDLE, disp_en = 0 and disp_data = 0, and the pending word is lost.
REQ-043 Deassert rstn mid-page, then release it -> all outputs are 0 asynchronously, and in_ready = 1 one edge after release.
REQ-044 With DISP_SCHED_GAP_EN defined -> 4 on-cycles and 2 cycles of disp_en = 0 per page; a word offered exactly at the GAP_LO terminal with pending empty is shown on the next cycle.
